// File: rtl/axis_frame_bridge.sv
// Packs a fixed-length AXI-Stream packet into a core frame, starts the core, then streams its result back out.
// Latency: start 1 cycle after the last RX beat, first TX beat 1 cycle after done; RX stalls outside S_RX, TX beats hold while m_axis_tready is low.
module axis_frame_bridge #(
    parameter int DATA_W   = 64,
    parameter int RX_BEATS = 10,
    parameter int TX_BEATS = 11
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [RX_BEATS*DATA_W-1:0]   o_core_frame,
    output logic                         o_core_start,
    input  logic [TX_BEATS*DATA_W-1:0]   i_core_result,
    input  logic                         i_core_done,
    output logic                         o_len_err,
    output logic [15:0]                  o_frame_cnt
);

    localparam int RXW = $clog2(RX_BEATS + 2);
    localparam int TXW = $clog2(TX_BEATS + 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(RX_BEATS - 1);
    localparam logic [RXW-1:0] RX_SAT  = RXW'(RX_BEATS);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TX_BEATS - 1);

    typedef enum logic [1:0] {S_RX, S_START, S_WAIT, S_TX} state_t;

    state_t                       state;
    logic [RXW-1:0]               rx_idx;
    logic [TXW-1:0]               tx_idx;
    logic [TXW-1:0]               tx_nxt;
    logic [TX_BEATS*DATA_W-1:0]   tx_reg;
    logic                         rx_acc;
    logic                         tx_acc;

    assign s_axis_tready = (state == S_RX) && !rst;
    assign rx_acc        = s_axis_tvalid && s_axis_tready;
    assign tx_acc        = m_axis_tvalid && m_axis_tready;
    assign tx_nxt        = tx_idx + TXW'(1);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state         <= S_RX;
            rx_idx        <= '0;
            tx_idx        <= '0;
            tx_reg        <= '0;
            o_core_frame  <= '0;
            o_core_start  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            o_len_err     <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_core_start <= 1'b0;
            case (state)
                S_RX: begin
                    if (rx_acc) begin
                        // Beats past the frame size are dropped; the index parks at RX_SAT so the length check still fails.
                        if (rx_idx < RX_SAT) begin
                            o_core_frame[int'(rx_idx)*DATA_W +: DATA_W] <= s_axis_tdata;
                        end
                        if (s_axis_tlast) begin
                            rx_idx <= '0;
                            if (rx_idx == RX_LAST) begin
                                state        <= S_START;
                                o_core_start <= 1'b1;
                            end else begin
                                o_len_err <= 1'b1;
                            end
                        end else if (rx_idx != RX_SAT) begin
                            rx_idx <= rx_idx + RXW'(1);
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_core_done) begin
                        tx_reg        <= i_core_result;
                        m_axis_tdata  <= i_core_result[DATA_W-1:0];
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (TX_BEATS == 1);
                        tx_idx        <= '0;
                        state         <= S_TX;
                    end
                end
                S_TX: begin
                    if (tx_acc) begin
                        if (tx_idx == TX_LAST) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            tx_idx        <= '0;
                            o_frame_cnt   <= o_frame_cnt + 16'd1;
                            state         <= S_RX;
                        end else begin
                            tx_idx       <= tx_nxt;
                            m_axis_tdata <= tx_reg[int'(tx_nxt)*DATA_W +: DATA_W];
                            m_axis_tlast <= (tx_nxt == TX_LAST);
                        end
                    end
                end
                default: begin
                    state <= S_RX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_bridge.sv
// Scoreboard bench for axis_frame_bridge: randomized packets and core results checked against a queue-based frame/beat model.
module tb_axis_frame_bridge;

    localparam int W   = 64;
    localparam int RXB = 10;
    localparam int TXB = 11;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic                 sys_clk = 1'b0;
    logic                 rst = 1'b1;
    logic [W-1:0]         s_axis_tdata = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tlast = 1'b0;
    logic                 s_axis_tready;
    logic [W-1:0]         m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready = 1'b0;
    logic [RXB*W-1:0]     o_core_frame;
    logic                 o_core_start;
    logic [TXB*W-1:0]     i_core_result = '0;
    logic                 i_core_done = 1'b0;
    logic                 o_len_err;
    logic [15:0]          o_frame_cnt;

    axis_frame_bridge #(.DATA_W(W), .RX_BEATS(RXB), .TX_BEATS(TXB)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .o_core_frame  (o_core_frame),
        .o_core_start  (o_core_start),
        .i_core_result (i_core_result),
        .i_core_done   (i_core_done),
        .o_len_err     (o_len_err),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0]     exp_frame [RXB];
    logic [RXB*W-1:0] frq [$];
    beat_t            txq [$];
    int               exp_cnt = 0;
    int               exp_starts = 0;
    int               act_starts = 0;
    logic             exp_len_err = 1'b0;
    int               last_acc_cyc = 0;
    int               done_cyc = 0;
    int               tx_seen = 0;
    int               tx_mode = 0;
    int               core_lat = 5;
    int               res_kind = 0;
    bit               garbage = 1'b0;
    bit               tr_force = 1'b0;

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_d(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_f(input string nm, input logic [RXB*W-1:0] act, input logic [RXB*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RXB*W-1:0] pack_frame();
        logic [RXB*W-1:0] f;
        for (int k = 0; k < RXB; k++) f[k*W +: W] = exp_frame[k];
        return f;
    endfunction

    task automatic model_reset();
        txq.delete();
        frq.delete();
        exp_cnt = 0;
        exp_len_err = 1'b0;
        for (int k = 0; k < RXB; k++) exp_frame[k] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) begin @(posedge sys_clk); #1; end
        rst = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int gap, input int kind);
        logic [W-1:0] b;
        bit ok;
        for (int k = 0; k < n; k++) begin
            b = (kind == 0) ? W'(k) : {$urandom, $urandom};
            if (k < RXB) exp_frame[k] = b;
            s_axis_tdata  = b;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (k == n - 1);
            ok = 1'b0;
            for (int t = 0; t < 2000; t++) begin
                @(negedge sys_clk);
                if (s_axis_tready) begin ok = 1'b1; break; end
            end
            if (ok && s_axis_tlast) begin
                last_acc_cyc = cyc;
                if (n == RXB) begin
                    frq.push_back(pack_frame());
                    exp_starts++;
                end else begin
                    exp_len_err = 1'b1;
                end
            end
            @(posedge sys_clk); #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            if (!ok) begin
                checks++; errors++;
                $display("FAIL rx_accept_timeout: beat %0d not accepted, expected within 2000 cycles", k);
                return;
            end
            repeat (gap) begin @(posedge sys_clk); #1; end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if (txq.size() == 0 && frq.size() == 0 && s_axis_tready && !m_axis_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: %0d beats and %0d frames still pending, expected 0", txq.size(), frq.size());
        end
        @(posedge sys_clk); #1;
    endtask

    // Core model: answers each start pulse after core_lat cycles; optionally holds a bogus done while idle.
    beat_t core_bt;
    initial forever begin
        @(negedge sys_clk);
        if (o_core_start && !rst) begin
            i_core_done = 1'b0;
            repeat (core_lat) @(posedge sys_clk);
            #1;
            for (int j = 0; j < TXB; j++) begin
                core_bt.d = (res_kind == 0) ? W'(256 + j) : {$urandom, $urandom};
                core_bt.l = (j == TXB - 1);
                i_core_result[j*W +: W] = core_bt.d;
                txq.push_back(core_bt);
            end
            exp_cnt++;
            done_cyc = cyc;
            i_core_done = 1'b1;
            @(posedge sys_clk); #1;
            i_core_done = 1'b0;
        end else begin
            i_core_done = garbage;
            if (garbage) begin
                for (int j = 0; j < TXB; j++) i_core_result[j*W +: W] = {$urandom, $urandom};
            end
        end
    end

    int pat = 0;
    initial forever begin
        @(posedge sys_clk); #2;
        if (!tr_force) begin
            case (tx_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (pat % 4 == 0) || (pat % 4 == 3);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            pat++;
        end
    end

    // Monitor: scoreboard for start pulses and output beats, plus stall/latency rules.
    logic         prev_stall = 1'b0;
    logic         prev_vld = 1'b0;
    logic         prev_l = 1'b0;
    logic [W-1:0] prev_d = '0;
    int           txbeat = 0;
    int           first_cyc = 0;
    beat_t        e;
    initial forever begin
        @(negedge sys_clk);
        if (rst) begin
            prev_stall = 1'b0;
            prev_vld   = 1'b0;
            txbeat     = 0;
        end else begin
            if (o_core_start) begin
                act_starts++;
                if (frq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start: start pulse at cycle %0d, expected none", cyc);
                end else begin
                    chk_f("core_frame", o_core_frame, frq.pop_front());
                    chk_i("start_latency", cyc, last_acc_cyc + 1);
                end
            end
            if (prev_stall) begin
                chk_i("stall_tvalid", int'(m_axis_tvalid), 1);
                chk_d("stall_tdata", m_axis_tdata, prev_d);
                chk_i("stall_tlast", int'(m_axis_tlast), int'(prev_l));
            end
            if (m_axis_tvalid && !prev_vld) chk_i("first_beat_latency", cyc, done_cyc + 1);
            if (m_axis_tvalid && m_axis_tready) begin
                tx_seen++;
                if (txq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: data %0h at cycle %0d, expected no beat", m_axis_tdata, cyc);
                end else begin
                    e = txq.pop_front();
                    chk_d("tx_data", m_axis_tdata, e.d);
                    chk_i("tx_last", int'(m_axis_tlast), int'(e.l));
                    if (txbeat == 0) first_cyc = cyc;
                    if (e.l) begin
                        if (tx_mode == 0) chk_i("tx_duration", cyc - first_cyc, TXB - 1);
                        txbeat = 0;
                    end else begin
                        txbeat++;
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
            prev_vld   = m_axis_tvalid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    int n;
    int base;
    bit ok;
    initial begin
        model_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_i("rst_s_tready", int'(s_axis_tready), 0);
        chk_i("rst_m_tvalid", int'(m_axis_tvalid), 0);
        chk_i("rst_m_tlast", int'(m_axis_tlast), 0);
        chk_i("rst_core_start", int'(o_core_start), 0);
        chk_i("rst_len_err", int'(o_len_err), 0);
        chk_i("rst_frame_cnt", int'(o_frame_cnt), 0);
        chk_d("rst_m_tdata", m_axis_tdata, '0);
        chk_f("rst_core_frame", o_core_frame, '0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        @(negedge sys_clk);
        chk_i("s_tready_after_reset", int'(s_axis_tready), 1);
        @(posedge sys_clk); #1;

        // Nominal: counting data, result beats 0x100.., done 5 cycles after start
        tx_mode = 0; res_kind = 0; core_lat = 5;
        send_pkt(RXB, 0, 0);
        wait_idle();
        chk_i("nominal_frame_cnt", int'(o_frame_cnt), exp_cnt);
        chk_i("nominal_len_err", int'(o_len_err), int'(exp_len_err));

        // TX backpressure 1,0,0,1
        tx_mode = 1; res_kind = 1;
        send_pkt(RXB, 0, 1);
        wait_idle();
        tx_mode = 0;
        chk_i("bp_frame_cnt", int'(o_frame_cnt), exp_cnt);

        // Short packet followed by a good one
        send_pkt(7, 0, 1);
        wait_idle();
        chk_i("short_len_err", int'(o_len_err), int'(exp_len_err));
        chk_f("short_frame", o_core_frame, pack_frame());
        send_pkt(RXB, 0, 1);
        wait_idle();
        chk_i("after_short_frame_cnt", int'(o_frame_cnt), exp_cnt);

        // Long packet from a clean error flag
        do_reset();
        send_pkt(RXB + 2, 0, 1);
        wait_idle();
        chk_i("long_len_err", int'(o_len_err), int'(exp_len_err));
        chk_f("long_frame", o_core_frame, pack_frame());
        chk_i("long_frame_cnt", int'(o_frame_cnt), exp_cnt);

        // RX gaps with a bogus done held while idle
        garbage = 1'b1;
        send_pkt(RXB, 3, 1);
        wait_idle();
        garbage = 1'b0;
        chk_i("gap_frame_cnt", int'(o_frame_cnt), exp_cnt);

        // Randomized traffic, sometimes back-to-back
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                tx_mode = $urandom_range(0, 2);
            end
            core_lat = $urandom_range(1, 8);
            case ($urandom_range(0, 3))
                0, 1:    n = RXB;
                2:       n = $urandom_range(1, RXB - 1);
                default: n = $urandom_range(RXB + 1, RXB + 3);
            endcase
            send_pkt(n, $urandom_range(0, 2), 1);
        end
        wait_idle();
        chk_i("rand_frame_cnt", int'(o_frame_cnt), exp_cnt);
        chk_i("rand_len_err", int'(o_len_err), int'(exp_len_err));
        chk_f("rand_frame", o_core_frame, pack_frame());

        // Reset after the fourth output beat
        tx_mode = 0; core_lat = 3;
        wait_idle();
        base = tx_seen;
        send_pkt(RXB, 0, 1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk);
            if (tx_seen >= base + 4) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL midtx_wait: %0d beats seen, expected 4", tx_seen - base);
        end
        #1;
        tr_force = 1'b1;
        m_axis_tready = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge sys_clk); #1;
        rst = 1'b0;
        tr_force = 1'b0;
        @(negedge sys_clk);
        chk_i("midtx_tvalid", int'(m_axis_tvalid), 0);
        chk_i("midtx_frame_cnt", int'(o_frame_cnt), 0);
        chk_i("midtx_len_err", int'(o_len_err), 0);
        chk_i("midtx_s_tready", int'(s_axis_tready), 1);
        @(posedge sys_clk); #1;
        send_pkt(RXB, 0, 1);
        wait_idle();
        chk_i("recover_frame_cnt", int'(o_frame_cnt), exp_cnt);
        chk_i("start_count", act_starts, exp_starts);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
